// File: rtl/datapath.sv
// Single-cycle 32-bit MIPS datapath: PC, instruction memory, register file,
// control decoder, ALU and data memory. Memory arrays are not reset; only the
// PC is cleared, and all architectural writes are held off while reset is low.

module imem #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        load_en,
  input  logic [5:0]  load_idx,
  input  logic [31:0] load_data,
  input  logic [5:0]  widx,
  output logic [31:0] instr
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [0:DEPTH-1];
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] ld_idx;

  assign rd_idx = AW'(32'(widx) % DEPTH);
  assign ld_idx = AW'(32'(load_idx) % DEPTH);
  assign instr  = mem[rd_idx];

  // Optional loader port; the datapath ties it off and programs are preloaded.
  always_ff @(posedge clk) begin
    if (load_en) mem[ld_idx] <= load_data;
  end
endmodule

module banco_de_registros (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] mem [0:31];

  // Register 0 always reads as zero, whatever the array holds.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : mem[ra2];

  // Single write port; writes aimed at register 0 are dropped.
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) mem[wa] <= wd;
  end
endmodule

module ram #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  widx,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [0:DEPTH-1];
  logic [AW-1:0] idx;

  assign idx = AW'(32'(widx) % DEPTH);
  assign rd  = mem[idx];

  // Word-wide synchronous store.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end
endmodule

module datapath #(
  parameter int IMEM_DEPTH = 64,
  parameter int RAM_DEPTH  = 64
) (
  input logic clk,
  input logic reset
);
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT
  } alu_op_t;

  logic [31:0] pc_reg, pc_next, pc4, branch_target, jump_target;
  logic [31:0] instr, imm_ext, rs_data, rt_data, alu_b, alu_result;
  logic [31:0] ram_rdata, wb_data;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_addr;
  logic        reg_write, reg_dst, alu_src, mem_write, mem_to_reg, branch, jump;
  alu_op_t     alu_op;
  logic        unused_shamt;

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];
  assign imm_ext      = {{16{instr[15]}}, instr[15:0]};

  imem #(.DEPTH(IMEM_DEPTH)) imem_inst (
    .clk       (clk),
    .load_en   (1'b0),
    .load_idx  (6'd0),
    .load_data (32'd0),
    .widx      (pc_reg[7:2]),
    .instr     (instr)
  );

  banco_de_registros banco_de_registros_inst (
    .clk (clk),
    .we  (reg_write && reset),
    .ra1 (rs),
    .ra2 (rt),
    .wa  (wb_addr),
    .wd  (wb_data),
    .rd1 (rs_data),
    .rd2 (rt_data)
  );

  ram #(.DEPTH(RAM_DEPTH)) ram_inst (
    .clk  (clk),
    .we   (mem_write && reset),
    .widx (alu_result[7:2]),
    .wd   (rt_data),
    .rd   (ram_rdata)
  );

  // Main decoder: unrecognised opcodes and R-type functs fall through as NOPs.
  always_comb begin
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_op     = ALU_ADD;
    case (opcode)
      6'h00: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        case (funct)
          6'h20:   alu_op = ALU_ADD;
          6'h22:   alu_op = ALU_SUB;
          6'h24:   alu_op = ALU_AND;
          6'h25:   alu_op = ALU_OR;
          6'h27:   alu_op = ALU_NOR;
          6'h2A:   alu_op = ALU_SLT;
          default: reg_write = 1'b0;
        endcase
      end
      6'h08: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      6'h23: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
      end
      6'h2B: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      6'h04:   branch = 1'b1;
      6'h02:   jump   = 1'b1;
      default: ;
    endcase
  end

  assign alu_b = alu_src ? imm_ext : rt_data;

  // ALU: 32-bit wrap-around arithmetic, signed set-less-than.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      ALU_ADD: alu_result = rs_data + alu_b;
      ALU_SUB: alu_result = rs_data - alu_b;
      ALU_AND: alu_result = rs_data & alu_b;
      ALU_OR:  alu_result = rs_data | alu_b;
      ALU_NOR: alu_result = ~(rs_data | alu_b);
      ALU_SLT: alu_result = ($signed(rs_data) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end

  assign wb_addr = reg_dst ? rd : rt;
  assign wb_data = mem_to_reg ? ram_rdata : alu_result;

  assign pc4           = pc_reg + 32'd4;
  assign branch_target = pc4 + {imm_ext[29:0], 2'b00};
  assign jump_target   = {pc4[31:28], instr[25:0], 2'b00};

  // Next-PC selection: jump, taken branch, or sequential.
  always_comb begin
    pc_next = pc4;
    if (jump)
      pc_next = jump_target;
    else if (branch && (rs_data == rt_data))
      pc_next = branch_target;
  end

  // Program counter, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_reg <= 32'd0;
    else        pc_reg <= pc_next;
  end
endmodule

// File: tb/tb_datapath.sv
// Bench for the single-cycle datapath: programs and state are loaded through
// the hierarchy, expected architectural state is queued as each program is set
// up, and the queue is drained against the DUT after the instructions retire.

module tb_datapath;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    int          kind;   // 0 = register, 1 = ram word, 2 = pc
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  datapath #(.IMEM_DEPTH(64), .RAM_DEPTH(64)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(logic [25:0] target);
    return {6'h02, target};
  endfunction

  function automatic logic [31:0] peek(int kind, int idx);
    case (kind)
      0:       return dut.banco_de_registros_inst.mem[idx];
      1:       return dut.ram_inst.mem[idx];
      default: return dut.pc_reg;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic push(input string tag, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, peek(e.kind, e.idx), e.val);
    end
  endtask

  // Hold the core in reset and wipe all memories (imem all NOP).
  task automatic clear_all();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dut.imem_inst.mem[i] = 32'd0;
      dut.ram_inst.mem[i]  = 32'd0;
    end
    for (int i = 0; i < 32; i++) dut.banco_de_registros_inst.mem[i] = 32'd0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // ---- 1: reset, then add ----
    #1;
    clear_all();
    dut.banco_de_registros_inst.mem[1] = 32'd5;
    dut.banco_de_registros_inst.mem[2] = 32'd7;
    dut.imem_inst.mem[0] = rtype(1, 2, 3, 6'h20);
    #1;
    check_val("reset_pc_async", dut.pc_reg, 32'd0);
    run(2);
    push("reset_pc_held", 2, 0, 32'd0);
    push("reset_no_write", 0, 3, 32'd0);
    drain();
    release_reset();
    run(1);
    push("add_r3", 0, 3, 32'd12);
    push("add_pc", 2, 0, 32'd4);
    drain();

    // ---- 2: sub/and/or/nor/slt and wrap ----
    clear_all();
    dut.banco_de_registros_inst.mem[1]  = 32'h0000000F;
    dut.banco_de_registros_inst.mem[2]  = 32'h000000F0;
    dut.banco_de_registros_inst.mem[11] = 32'h77;
    dut.banco_de_registros_inst.mem[15] = 32'h5A;
    dut.imem_inst.mem[0] = rtype(1, 2, 4, 6'h22);
    dut.imem_inst.mem[1] = rtype(1, 2, 5, 6'h24);
    dut.imem_inst.mem[2] = rtype(1, 2, 6, 6'h25);
    dut.imem_inst.mem[3] = rtype(1, 2, 7, 6'h27);
    dut.imem_inst.mem[4] = rtype(1, 2, 8, 6'h2A);
    dut.imem_inst.mem[5] = rtype(2, 1, 11, 6'h2A);
    dut.imem_inst.mem[6] = itype(6'h08, 0, 13, 16'hFFFF);
    dut.imem_inst.mem[7] = rtype(13, 1, 14, 6'h2A);
    dut.imem_inst.mem[8] = rtype(1, 2, 15, 6'h21);
    dut.imem_inst.mem[9] = rtype(13, 13, 12, 6'h20);
    push("sub_r4", 0, 4, 32'hFFFFFF1F);
    push("and_r5", 0, 5, 32'h00000000);
    push("or_r6", 0, 6, 32'h000000FF);
    push("nor_r7", 0, 7, 32'hFFFFFF00);
    push("slt_true_r8", 0, 8, 32'd1);
    push("slt_false_r11", 0, 11, 32'd0);
    push("addi_neg_r13", 0, 13, 32'hFFFFFFFF);
    push("slt_signed_r14", 0, 14, 32'd1);
    push("bad_funct_nop_r15", 0, 15, 32'h5A);
    push("add_wrap_r12", 0, 12, 32'hFFFFFFFE);
    push("seq_pc", 2, 0, 32'd40);
    release_reset();
    run(10);
    drain();

    // ---- 3: lw/sw ----
    clear_all();
    dut.ram_inst.mem[2] = 32'hDEADBEEF;
    dut.ram_inst.mem[0] = 32'h12345678;
    dut.banco_de_registros_inst.mem[20] = 32'd16;
    dut.imem_inst.mem[0] = itype(6'h23, 1, 9, 16'd8);
    dut.imem_inst.mem[1] = itype(6'h2B, 1, 9, 16'd12);
    dut.imem_inst.mem[2] = itype(6'h23, 20, 16, 16'hFFFC);
    dut.imem_inst.mem[3] = itype(6'h23, 1, 19, 16'd256);
    dut.imem_inst.mem[4] = itype(6'h3F, 1, 21, 16'd1);
    push("lw_r9", 0, 9, 32'hDEADBEEF);
    push("sw_ram3", 1, 3, 32'hDEADBEEF);
    push("lw_negoff_r16", 0, 16, 32'hDEADBEEF);
    push("lw_wrap_r19", 0, 19, 32'h12345678);
    push("bad_op_nop_r21", 0, 21, 32'd0);
    push("mem_pc", 2, 0, 32'd20);
    release_reset();
    run(5);
    drain();

    // ---- 4: writes to register 0 ----
    clear_all();
    dut.banco_de_registros_inst.mem[10] = 32'h55;
    dut.imem_inst.mem[0] = itype(6'h08, 0, 0, 16'd5);
    dut.imem_inst.mem[1] = rtype(0, 0, 10, 6'h20);
    push("r0_not_written", 0, 0, 32'd0);
    push("r0_reads_zero_r10", 0, 10, 32'd0);
    release_reset();
    run(2);
    drain();
    clear_all();
    dut.banco_de_registros_inst.mem[0]  = 32'h99;
    dut.banco_de_registros_inst.mem[11] = 32'h44;
    dut.imem_inst.mem[0] = rtype(0, 0, 11, 6'h20);
    push("r0_forced_zero_r11", 0, 11, 32'd0);
    release_reset();
    run(1);
    drain();

    // ---- 5: branch and jump ----
    clear_all();
    dut.banco_de_registros_inst.mem[1] = 32'd3;
    dut.banco_de_registros_inst.mem[2] = 32'd3;
    dut.imem_inst.mem[0] = itype(6'h04, 1, 2, 16'd2);
    dut.imem_inst.mem[1] = itype(6'h08, 0, 5, 16'd1);
    dut.imem_inst.mem[2] = itype(6'h08, 0, 6, 16'd1);
    dut.imem_inst.mem[3] = jtype(26'd0);
    release_reset();
    run(1);
    push("beq_taken_pc", 2, 0, 32'd12);
    drain();
    run(1);
    push("j_pc", 2, 0, 32'd0);
    push("skip_r5", 0, 5, 32'd0);
    push("skip_r6", 0, 6, 32'd0);
    drain();
    reset = 1'b0;
    dut.banco_de_registros_inst.mem[2] = 32'd4;
    release_reset();
    run(1);
    push("beq_not_taken_pc", 2, 0, 32'd4);
    drain();
    run(1);
    push("after_fallthrough_r5", 0, 5, 32'd1);
    drain();

    // ---- 6: async reset mid-run ----
    clear_all();
    dut.banco_de_registros_inst.mem[1] = 32'd5;
    dut.banco_de_registros_inst.mem[2] = 32'd7;
    dut.imem_inst.mem[0] = rtype(1, 2, 3, 6'h20);
    for (int i = 1; i < 5; i++) dut.imem_inst.mem[i] = itype(6'h08, 17, 17, 16'd1);
    dut.imem_inst.mem[5] = itype(6'h08, 0, 18, 16'd7);
    release_reset();
    run(5);
    push("midrun_pc", 2, 0, 32'd20);
    push("midrun_r17", 0, 17, 32'd4);
    drain();
    dut.banco_de_registros_inst.mem[3] = 32'd0;
    #2;
    reset = 1'b0;
    #1;
    check_val("async_pc_clear", dut.pc_reg, 32'd0);
    run(3);
    push("held_pc", 2, 0, 32'd0);
    push("held_r18", 0, 18, 32'd0);
    push("held_r17", 0, 17, 32'd4);
    push("held_r3", 0, 3, 32'd0);
    drain();
    reset = 1'b1;
    run(1);
    push("resume_r3", 0, 3, 32'd12);
    push("resume_pc", 2, 0, 32'd4);
    push("resume_r17", 0, 17, 32'd4);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
